// File: rtl/simeck_round_scheduler.sv
// Iterative Simeck-style Feistel core: one round per cycle, round keys fetched via rk_req/rk_idx.
// Optional SIMECK_ABORT_EN adds an abort input that cancels a running operation.
module simeck_round_scheduler #(
  parameter int DATAW   = 16,
  parameter int ROUNDS  = 32,
  parameter int SHIFT_A = 5,
  parameter int SHIFT_B = 1,
  localparam int IDXW   = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [2*DATAW-1:0] din,
  output logic               rk_req,
  output logic [IDXW-1:0]    rk_idx,
  input  logic               rk_valid,
  input  logic [DATAW-1:0]   rk_in,
`ifdef SIMECK_ABORT_EN
  input  logic               abort,
`endif
  output logic               busy,
  output logic               dout_valid,
  output logic [2*DATAW-1:0] dout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ROUNDS - 1);

  logic [1:0]         state_q, state_d;
  logic [IDXW-1:0]    cnt_q, cnt_d;
  logic [DATAW-1:0]   l_q, l_d;
  logic [DATAW-1:0]   r_q, r_d;
  logic               mode_q, mode_d;
  logic [2*DATAW-1:0] dout_q, dout_d;

  logic [DATAW-1:0]   rnd_l, rnd_r;
  logic               abort_w;

`ifdef SIMECK_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  function automatic logic [DATAW-1:0] rotl(input logic [DATAW-1:0] x, input int unsigned s);
    logic [DATAW-1:0] y;
    y = '0;
    for (int unsigned i = 0; i < DATAW; i++) begin
      y[(i + s) % DATAW] = x[i];
    end
    return y;
  endfunction

  function automatic logic [DATAW-1:0] f_fn(input logic [DATAW-1:0] x);
    return (x & rotl(x, SHIFT_A)) ^ rotl(x, SHIFT_B);
  endfunction

  // Encrypt and decrypt rounds are mirror images; decrypt undoes one encrypt round with the same key.
  always_comb begin
    if (mode_q) begin
      rnd_l = r_q;
      rnd_r = l_q ^ f_fn(r_q) ^ rk_in;
    end else begin
      rnd_l = r_q ^ f_fn(l_q) ^ rk_in;
      rnd_r = l_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    r_d     = r_q;
    mode_d  = mode_q;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          l_d     = din[2*DATAW-1:DATAW];
          r_d     = din[DATAW-1:0];
          mode_d  = mode;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort_w) begin
          state_d = S_IDLE;
        end else if (rk_valid) begin
          l_d = rnd_l;
          r_d = rnd_r;
          if (cnt_q == LAST_IDX) begin
            state_d = S_DONE;
            dout_d  = {rnd_l, rnd_r};
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      mode_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      r_q     <= r_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
    end
  end

  assign rk_req     = (state_q == S_RUN);
  assign rk_idx     = rk_req ? (mode_q ? (LAST_IDX - cnt_q) : cnt_q) : '0;
  assign busy       = (state_q != S_IDLE);
  assign dout_valid = (state_q == S_DONE);
  assign dout       = dout_q;

endmodule

// File: tb/tb_simeck_round_scheduler.sv
// Directed/random bench for simeck_round_scheduler with a loop-level Feistel reference model.
module tb_simeck_round_scheduler;

  logic        clk = 1'b0;
  logic        rst, start, mode, rk_valid, abort;
  logic [31:0] din, dout;
  logic [4:0]  rk_idx;
  logic [15:0] rk_in;
  logic        rk_req, busy, dout_valid;
  logic [15:0] key_tab [32];

  logic        start1, rk_valid1, abort1, mode1;
  logic [31:0] din1, dout1;
  logic [0:0]  rk_idx1;
  logic [15:0] rk_in1;
  logic        rk_req1, busy1, dv1;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign rk_in = key_tab[rk_idx];

  simeck_round_scheduler u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .din(din),
    .rk_req(rk_req), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_in(rk_in),
`ifdef SIMECK_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .dout_valid(dout_valid), .dout(dout)
  );

  simeck_round_scheduler #(.ROUNDS(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode1), .din(din1),
    .rk_req(rk_req1), .rk_idx(rk_idx1), .rk_valid(rk_valid1), .rk_in(rk_in1),
`ifdef SIMECK_ABORT_EN
    .abort(abort1),
`endif
    .busy(busy1), .dout_valid(dv1), .dout(dout1)
  );

  function automatic logic [15:0] m_rotl(input logic [15:0] x, input int s);
    logic [31:0] t;
    t = {x, x} << (s % 16);
    return t[31:16];
  endfunction

  function automatic logic [15:0] m_f(input logic [15:0] x);
    return (x & m_rotl(x, 5)) ^ m_rotl(x, 1);
  endfunction

  function automatic logic [31:0] m_crypt(input logic m, input logic [31:0] d);
    logic [15:0] l, r, t;
    l = d[31:16];
    r = d[15:0];
    for (int i = 0; i < 32; i++) begin
      if (!m) begin
        t = r ^ m_f(l) ^ key_tab[i];
        r = l;
        l = t;
      end else begin
        t = l ^ m_f(r) ^ key_tab[31 - i];
        l = r;
        r = t;
      end
    end
    return {l, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic run_op(input logic m, input logic [31:0] d, input int stall_at,
                        input int stall_len, input bit inject,
                        output logic [31:0] res, output int lat);
    int  round, stalls, cyc;
    bit  done;
    mode = m; din = d; start = 1'b1; rk_valid = 1'b1;
    step();
    start = 1'b0; mode = ~m; din = $urandom;
    chk("busy_rise", busy, 1);
    cyc = 1; round = 0; stalls = 0; done = 1'b0;
    while (!done && cyc < 200) begin
      if (dout_valid) begin
        done = 1'b1;
      end else begin
        chk("rk_req", rk_req, 1);
        chk(m ? "rk_idx_dec" : "rk_idx_enc", rk_idx, m ? 31 - round : round);
        if (round == stall_at && stalls < stall_len) begin
          rk_valid = 1'b0;
          stalls++;
        end else begin
          rk_valid = 1'b1;
          round++;
        end
        start = inject && (round == 4);
        din = $urandom;
        step();
        cyc++;
      end
    end
    rk_valid = 1'b1;
    start = 1'b0;
    if (!done) chk("timeout_dv", dout_valid, 1);
    res = dout;
    lat = cyc;
    if (inject) begin
      start = 1'b1;
      din = $urandom;
    end
    step();
    start = 1'b0;
    chk("idle_after_done", busy, 0);
    chk("dv_one_cycle", dout_valid, 0);
    chk("dout_hold", dout, res);
  endtask

  task automatic run_intr(input bit use_abort, input int at, input logic [31:0] d);
    logic [31:0] prev;
    int cyc;
    bit seen;
    prev = dout;
    mode = 1'b0; din = d; start = 1'b1; rk_valid = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (rk_idx != 5'(at) && cyc < 100) begin
      step();
      cyc++;
    end
    chk("intr_reach", rk_idx, at);
    if (use_abort) abort = 1'b1;
    else rst = 1'b1;
    step();
    abort = 1'b0; rst = 1'b0;
    chk("intr_busy", busy, 0);
    chk("intr_dout", dout, use_abort ? prev : 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dout_valid) seen = 1'b1;
      step();
    end
    chk("intr_no_dv", seen, 0);
  endtask

  initial begin
    logic [31:0] d, ct, pt, ref_nostall, r;
    int lat;

    rst = 1'b1; start = 1'b0; mode = 1'b0; rk_valid = 1'b1; abort = 1'b0; din = '0;
    start1 = 1'b0; rk_valid1 = 1'b1; abort1 = 1'b0; mode1 = 1'b0; din1 = '0; rk_in1 = '0;
    for (int i = 0; i < 32; i++) key_tab[i] = '0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_rk_req", rk_req, 0);
    chk("rst_dv", dout_valid, 0);
    chk("rst_rk_idx", rk_idx, 0);
    chk("rst_dout", dout, 0);
    rst = 1'b0;
    step();

    // single-round instance
    start1 = 1'b1; din1 = 32'h0001_0000;
    step();
    start1 = 1'b0; din1 = '0;
    chk("r1_dv_c1", dv1, 0);
    step();
    chk("r1_dv_c2", dv1, 1);
    chk("r1_dout", dout1, 32'h0002_0001);
    step();

    // all-zero encrypt
    run_op(1'b0, 32'h0, -1, 0, 1'b0, r, lat);
    chk("zero_dout", r, 32'h0);
    chk("zero_latency", lat, 33);

    for (int i = 0; i < 32; i++) key_tab[i] = 16'($urandom);
    for (int k = 0; k < 3; k++) begin
      d = $urandom;
      run_op(1'b0, d, -1, 0, 1'b0, ct, lat);
      chk("enc_model", ct, m_crypt(1'b0, d));
      chk("enc_latency", lat, 33);
      run_op(1'b1, ct, -1, 0, 1'b0, pt, lat);
      chk("dec_model", pt, m_crypt(1'b1, ct));
      chk("roundtrip", pt, d);
    end

    // stall of 3 cycles at round 5
    d = $urandom;
    run_op(1'b0, d, -1, 0, 1'b0, ref_nostall, lat);
    run_op(1'b0, d, 5, 3, 1'b0, r, lat);
    chk("stall_model", r, m_crypt(1'b0, d));
    chk("stall_eq_nostall", r, ref_nostall);
    chk("stall_latency", lat, 36);

    // start pulses during RUN and DONE
    d = $urandom;
    run_op(1'b0, d, -1, 0, 1'b1, r, lat);
    chk("inject_model", r, m_crypt(1'b0, d));
    chk("inject_latency", lat, 33);

    // reset at round 10, then a normal run
    run_intr(1'b0, 10, $urandom);
    d = $urandom;
    run_op(1'b1, d, -1, 0, 1'b0, r, lat);
    chk("post_rst_model", r, m_crypt(1'b1, d));

`ifdef SIMECK_ABORT_EN
    run_intr(1'b1, 7, $urandom);
    d = $urandom;
    run_op(1'b0, d, -1, 0, 1'b0, r, lat);
    chk("post_abort_model", r, m_crypt(1'b0, d));
    chk("post_abort_latency", lat, 33);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
